// File: rtl/rs_alu_multi_dispatch_pkg.sv
// Shared defaults, ALU opcode encodings and width helpers for the ALU reservation station.
package rs_alu_multi_dispatch_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int OP_WIDTH_DEF  = 5;
  localparam int RS_WIDTH_DEF  = 3;
  localparam int ROB_WIDTH_DEF = 4;
  localparam int NUM_CDB_DEF   = 2;
  localparam int NUM_ALU_DEF   = 2;

  typedef enum logic [OP_WIDTH_DEF-1:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_SLL = 5'd5,
    ALU_SRL = 5'd6,
    ALU_SRA = 5'd7
  } alu_op_e;

  // Index width that never collapses to zero for single-bit vectors.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_alu_multi_dispatch_pick.sv
// rs_pick_first: lowest-index request wins; returns one-hot grant, binary index and any-request flag.
module rs_pick_first
  import rs_alu_multi_dispatch_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two's-complement isolate of the lowest set bit.
  assign grant = req & (~req + 1'b1);
  assign any   = |req;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/rs_alu_multi_dispatch.sv
// ALU reservation station: holds issued ops until both operands are valid (CDB wakeup / issue bypass)
// and hands ready entries to NUM_ALU valid/ready dispatch ports in ascending entry order.
module rs_alu_multi_dispatch
  import rs_alu_multi_dispatch_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int RS_WIDTH  = RS_WIDTH_DEF,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int NUM_CDB   = NUM_CDB_DEF,
  parameter int NUM_ALU   = NUM_ALU_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           issue_in,
  input  logic [OP_WIDTH-1:0]            issue_opcode_in,
  input  logic [XLEN-1:0]                issue_val1_in,
  input  logic [XLEN-1:0]                issue_val2_in,
  input  logic [ROB_WIDTH-1:0]           issue_tag1_in,
  input  logic [ROB_WIDTH-1:0]           issue_tag2_in,
  input  logic                           issue_rdy1_in,
  input  logic                           issue_rdy2_in,
  input  logic [ROB_WIDTH-1:0]           issue_rd_tag_in,
  input  logic [NUM_CDB-1:0]             cdb_valid_in,
  input  logic [NUM_CDB*ROB_WIDTH-1:0]   cdb_tag_in,
  input  logic [NUM_CDB*XLEN-1:0]        cdb_value_in,
  output logic [NUM_ALU-1:0]             alu_valid_out,
  input  logic [NUM_ALU-1:0]             alu_ready_in,
  output logic [NUM_ALU*OP_WIDTH-1:0]    alu_opcode_out,
  output logic [NUM_ALU*XLEN-1:0]        alu_lhs_out,
  output logic [NUM_ALU*XLEN-1:0]        alu_rhs_out,
  output logic [NUM_ALU*ROB_WIDTH-1:0]   alu_rd_tag_out,
  output logic                           full_out,
  output logic [RS_WIDTH:0]              free_count_out
);

  localparam int RS_SIZE = 2 ** RS_WIDTH;
  localparam int CW      = RS_WIDTH + 1;

  logic [RS_SIZE-1:0]   busy_reg, v1_reg, v2_reg;
  logic [OP_WIDTH-1:0]  op_reg   [RS_SIZE];
  logic [XLEN-1:0]      val1_reg [RS_SIZE];
  logic [XLEN-1:0]      val2_reg [RS_SIZE];
  logic [ROB_WIDTH-1:0] tag1_reg [RS_SIZE];
  logic [ROB_WIDTH-1:0] tag2_reg [RS_SIZE];
  logic [ROB_WIDTH-1:0] rd_reg   [RS_SIZE];

  logic [NUM_ALU-1:0]           alu_valid_reg;
  logic [NUM_ALU*OP_WIDTH-1:0]  alu_op_reg;
  logic [NUM_ALU*XLEN-1:0]      alu_lhs_reg, alu_rhs_reg;
  logic [NUM_ALU*ROB_WIDTH-1:0] alu_rd_reg;

  // CDB match: scan ports high to low so the lowest matching port wins.
  logic [RS_SIZE-1:0] wake1, wake2;
  logic [XLEN-1:0]    wake1_val [RS_SIZE];
  logic [XLEN-1:0]    wake2_val [RS_SIZE];
  logic               ihit1, ihit2;
  logic [XLEN-1:0]    ihit1_val, ihit2_val;

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    ihit1 = 1'b0;
    ihit2 = 1'b0;
    ihit1_val = '0;
    ihit2_val = '0;
    for (int e = 0; e < RS_SIZE; e++) begin
      wake1_val[e] = '0;
      wake2_val[e] = '0;
    end
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid_in[k]) begin
        for (int e = 0; e < RS_SIZE; e++) begin
          if (cdb_tag_in[k*ROB_WIDTH +: ROB_WIDTH] == tag1_reg[e]) begin
            wake1[e] = 1'b1;
            wake1_val[e] = cdb_value_in[k*XLEN +: XLEN];
          end
          if (cdb_tag_in[k*ROB_WIDTH +: ROB_WIDTH] == tag2_reg[e]) begin
            wake2[e] = 1'b1;
            wake2_val[e] = cdb_value_in[k*XLEN +: XLEN];
          end
        end
        if (cdb_tag_in[k*ROB_WIDTH +: ROB_WIDTH] == issue_tag1_in) begin
          ihit1 = 1'b1;
          ihit1_val = cdb_value_in[k*XLEN +: XLEN];
        end
        if (cdb_tag_in[k*ROB_WIDTH +: ROB_WIDTH] == issue_tag2_in) begin
          ihit2 = 1'b1;
          ihit2_val = cdb_value_in[k*XLEN +: XLEN];
        end
      end
    end
    wake1 = wake1 & busy_reg & ~v1_reg;
    wake2 = wake2 & busy_reg & ~v2_reg;
  end

  // Free-slot allocation works on registered busy, so a slot freed this edge is reused next cycle at the earliest.
  logic [RS_SIZE-1:0]  alloc_grant;
  logic [RS_WIDTH-1:0] alloc_idx;
  logic                alloc_any, alloc_en;

  rs_pick_first #(.N(RS_SIZE), .IW(RS_WIDTH)) u_alloc (
    .req   (~busy_reg),
    .grant (alloc_grant),
    .idx   (alloc_idx),
    .any   (alloc_any)
  );
  assign alloc_en = issue_in && alloc_any;

  // Dispatch chain: each loading port masks its pick out of the request vector seen by later ports.
  logic [NUM_ALU:0][RS_SIZE-1:0]     avail;
  logic [NUM_ALU-1:0][RS_SIZE-1:0]   load_grant;
  logic [NUM_ALU-1:0][RS_WIDTH-1:0]  load_idx;
  logic [NUM_ALU-1:0]                load;
  logic [RS_SIZE-1:0]                disp_mask;

  assign avail[0] = busy_reg & v1_reg & v2_reg;

  generate
    for (genvar gi = 0; gi < NUM_ALU; gi++) begin : g_port
      logic [RS_SIZE-1:0] pick_grant;
      logic               pick_any;
      rs_pick_first #(.N(RS_SIZE), .IW(RS_WIDTH)) u_pick (
        .req   (avail[gi]),
        .grant (pick_grant),
        .idx   (load_idx[gi]),
        .any   (pick_any)
      );
      assign load[gi]       = pick_any && (!alu_valid_reg[gi] || alu_ready_in[gi]);
      assign load_grant[gi] = load[gi] ? pick_grant : '0;
      assign avail[gi+1]    = avail[gi] & ~pick_grant | (load[gi] ? '0 : avail[gi] & pick_grant);
    end
  endgenerate

  always_comb begin
    disp_mask = '0;
    for (int k = 0; k < NUM_ALU; k++) disp_mask = disp_mask | load_grant[k];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_reg <= '0;
      v1_reg   <= '0;
      v2_reg   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_reg <= '0;
      end else begin
        busy_reg <= (busy_reg & ~disp_mask) | (alloc_en ? alloc_grant : '0);
        v1_reg   <= v1_reg | wake1;
        v2_reg   <= v2_reg | wake2;
        if (alloc_en) begin
          v1_reg[alloc_idx] <= issue_rdy1_in || ihit1;
          v2_reg[alloc_idx] <= issue_rdy2_in || ihit2;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      for (int e = 0; e < RS_SIZE; e++) begin
        if (wake1[e]) val1_reg[e] <= wake1_val[e];
        if (wake2[e]) val2_reg[e] <= wake2_val[e];
      end
      if (alloc_en) begin
        op_reg[alloc_idx]   <= issue_opcode_in;
        val1_reg[alloc_idx] <= issue_rdy1_in ? issue_val1_in : ihit1_val;
        val2_reg[alloc_idx] <= issue_rdy2_in ? issue_val2_in : ihit2_val;
        tag1_reg[alloc_idx] <= issue_tag1_in;
        tag2_reg[alloc_idx] <= issue_tag2_in;
        rd_reg[alloc_idx]   <= issue_rd_tag_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      alu_valid_reg <= '0;
      alu_op_reg    <= '0;
      alu_lhs_reg   <= '0;
      alu_rhs_reg   <= '0;
      alu_rd_reg    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        alu_valid_reg <= '0;
      end else begin
        for (int k = 0; k < NUM_ALU; k++) begin
          if (load[k]) begin
            alu_valid_reg[k]                    <= 1'b1;
            alu_op_reg[k*OP_WIDTH +: OP_WIDTH]  <= op_reg[load_idx[k]];
            alu_lhs_reg[k*XLEN +: XLEN]         <= val1_reg[load_idx[k]];
            alu_rhs_reg[k*XLEN +: XLEN]         <= val2_reg[load_idx[k]];
            alu_rd_reg[k*ROB_WIDTH +: ROB_WIDTH] <= rd_reg[load_idx[k]];
          end else if (alu_ready_in[k]) begin
            alu_valid_reg[k] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    free_count_out = '0;
    for (int e = 0; e < RS_SIZE; e++) free_count_out = free_count_out + CW'(!busy_reg[e]);
  end

  assign full_out       = &busy_reg;
  assign alu_valid_out  = alu_valid_reg;
  assign alu_opcode_out = alu_op_reg;
  assign alu_lhs_out    = alu_lhs_reg;
  assign alu_rhs_out    = alu_rhs_reg;
  assign alu_rd_tag_out = alu_rd_reg;

endmodule

// File: tb/tb_rs_alu_multi_dispatch.sv
// Directed bench for rs_alu_multi_dispatch: reset, ready issue, wakeup/bypass, backpressure, full, pause/flush.
module tb_rs_alu_multi_dispatch;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in, issue_in;
  logic [4:0]  issue_opcode_in;
  logic [31:0] issue_val1_in, issue_val2_in;
  logic [3:0]  issue_tag1_in, issue_tag2_in, issue_rd_tag_in;
  logic        issue_rdy1_in, issue_rdy2_in;
  logic [1:0]  cdb_valid_in;
  logic [7:0]  cdb_tag_in;
  logic [63:0] cdb_value_in;
  logic [1:0]  alu_valid_out, alu_ready_in;
  logic [9:0]  alu_opcode_out;
  logic [63:0] alu_lhs_out, alu_rhs_out;
  logic [7:0]  alu_rd_tag_out;
  logic        full_out;
  logic [3:0]  free_count_out;

  int compared   = 0;
  int mismatched = 0;

  rs_alu_multi_dispatch dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_in(issue_in), .issue_opcode_in(issue_opcode_in),
    .issue_val1_in(issue_val1_in), .issue_val2_in(issue_val2_in),
    .issue_tag1_in(issue_tag1_in), .issue_tag2_in(issue_tag2_in),
    .issue_rdy1_in(issue_rdy1_in), .issue_rdy2_in(issue_rdy2_in),
    .issue_rd_tag_in(issue_rd_tag_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .alu_valid_out(alu_valid_out), .alu_ready_in(alu_ready_in),
    .alu_opcode_out(alu_opcode_out), .alu_lhs_out(alu_lhs_out), .alu_rhs_out(alu_rhs_out),
    .alu_rd_tag_out(alu_rd_tag_out), .full_out(full_out), .free_count_out(free_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic r1, input logic [3:0] t1, input logic [3:0] rd);
    issue_in        = 1'b1;
    issue_opcode_in = op;
    issue_val1_in   = v1;
    issue_val2_in   = v2;
    issue_rdy1_in   = r1;
    issue_tag1_in   = t1;
    issue_rdy2_in   = 1'b1;
    issue_tag2_in   = 4'd0;
    issue_rd_tag_in = rd;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; issue_in = 1'b0;
    issue_opcode_in = '0; issue_val1_in = '0; issue_val2_in = '0;
    issue_tag1_in = '0; issue_tag2_in = '0; issue_rdy1_in = 1'b0; issue_rdy2_in = 1'b0;
    issue_rd_tag_in = '0; cdb_valid_in = '0; cdb_tag_in = '0; cdb_value_in = '0;
    alu_ready_in = 2'b11;

    // 1. reset
    tick(); tick();
    check("reset_valid", 64'(alu_valid_out), 64'd0);
    check("reset_full", 64'(full_out), 64'd0);
    check("reset_free", 64'(free_count_out), 64'd8);
    check("reset_lhs", alu_lhs_out, 64'd0);
    rst_n_in = 1'b1;
    tick();

    // 2. ready issue
    set_issue(5'd3, 32'd5, 32'd7, 1'b1, 4'd0, 4'd1);
    tick();
    issue_in = 1'b0;
    check("rdy_alloc_free", 64'(free_count_out), 64'd7);
    check("rdy_alloc_valid", 64'(alu_valid_out), 64'd0);
    tick();
    check("rdy_disp_valid", 64'(alu_valid_out), 64'b01);
    check("rdy_disp_lhs", 64'(alu_lhs_out[31:0]), 64'd5);
    check("rdy_disp_rhs", 64'(alu_rhs_out[31:0]), 64'd7);
    check("rdy_disp_op", 64'(alu_opcode_out[4:0]), 64'd3);
    check("rdy_disp_rd", 64'(alu_rd_tag_out[3:0]), 64'd1);
    check("rdy_disp_free", 64'(free_count_out), 64'd8);
    tick();
    check("rdy_drop_valid", 64'(alu_valid_out), 64'd0);

    // 3. wakeup two cycles after issue, then same-cycle bypass
    set_issue(5'd2, 32'd0, 32'd9, 1'b0, 4'd4, 4'd2);
    tick();
    issue_in = 1'b0;
    check("wk_alloc_free", 64'(free_count_out), 64'd7);
    tick();
    check("wk_wait_valid", 64'(alu_valid_out), 64'd0);
    cdb_valid_in = 2'b01; cdb_tag_in = {4'd0, 4'd4}; cdb_value_in = {32'd0, 32'hDEAD};
    tick();
    cdb_valid_in = 2'b00;
    check("wk_same_edge_valid", 64'(alu_valid_out), 64'd0);
    tick();
    check("wk_disp_valid", 64'(alu_valid_out), 64'b01);
    check("wk_disp_lhs", 64'(alu_lhs_out[31:0]), 64'hDEAD);
    check("wk_disp_rhs", 64'(alu_rhs_out[31:0]), 64'd9);
    tick();
    set_issue(5'd4, 32'd0, 32'd11, 1'b0, 4'd4, 4'd3);
    cdb_valid_in = 2'b11; cdb_tag_in = {4'd4, 4'd4}; cdb_value_in = {32'h1111, 32'hBEEF};
    tick();
    issue_in = 1'b0; cdb_valid_in = 2'b00;
    check("byp_alloc_valid", 64'(alu_valid_out), 64'd0);
    tick();
    check("byp_disp_valid", 64'(alu_valid_out), 64'b01);
    check("byp_disp_lhs", 64'(alu_lhs_out[31:0]), 64'hBEEF);
    check("byp_disp_rd", 64'(alu_rd_tag_out[3:0]), 64'd3);
    tick();

    // 4. backpressure
    alu_ready_in = 2'b00;
    for (int i = 0; i < 3; i++) begin
      set_issue(5'(10 + i), 32'(100 + i), 32'(200 + i), 1'b1, 4'd0, 4'(5 + i));
      tick();
    end
    issue_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 64'(alu_valid_out), 64'b11);
      check("bp_hold_lhs0", 64'(alu_lhs_out[31:0]), 64'd100);
      check("bp_hold_lhs1", 64'(alu_lhs_out[63:32]), 64'd101);
      check("bp_hold_free", 64'(free_count_out), 64'd7);
    end
    alu_ready_in = 2'b01;
    tick();
    check("bp_load2_valid", 64'(alu_valid_out), 64'b11);
    check("bp_load2_lhs0", 64'(alu_lhs_out[31:0]), 64'd102);
    check("bp_load2_op0", 64'(alu_opcode_out[4:0]), 64'd12);
    check("bp_load2_lhs1", 64'(alu_lhs_out[63:32]), 64'd101);
    check("bp_load2_free", 64'(free_count_out), 64'd8);
    alu_ready_in = 2'b11;
    tick();
    check("bp_drop_valid", 64'(alu_valid_out), 64'd0);

    // 5. fill, overflow attempt, wakeup, flush
    alu_ready_in = 2'b00;
    for (int i = 0; i < 8; i++) begin
      set_issue(5'd1, 32'd0, 32'(i), 1'b0, 4'd7, 4'(i));
      tick();
    end
    check("full_flag", 64'(full_out), 64'd1);
    check("full_free", 64'(free_count_out), 64'd0);
    set_issue(5'd1, 32'd0, 32'd99, 1'b1, 4'd0, 4'd15);
    tick();
    issue_in = 1'b0;
    check("full_9th_flag", 64'(full_out), 64'd1);
    check("full_9th_valid", 64'(alu_valid_out), 64'd0);
    cdb_valid_in = 2'b10; cdb_tag_in = {4'd7, 4'd0}; cdb_value_in = {32'h77, 32'h0};
    tick();
    cdb_valid_in = 2'b00;
    tick();
    check("full_wake_valid", 64'(alu_valid_out), 64'b11);
    check("full_wake_lhs1", 64'(alu_lhs_out[63:32]), 64'h77);
    check("full_wake_rhs1", 64'(alu_rhs_out[63:32]), 64'd1);
    check("full_wake_free", 64'(free_count_out), 64'd2);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("flush_full", 64'(full_out), 64'd0);
    check("flush_free", 64'(free_count_out), 64'd8);
    check("flush_valid", 64'(alu_valid_out), 64'd0);
    alu_ready_in = 2'b11;

    // 6. pause and flush corners
    set_issue(5'd6, 32'd0, 32'd3, 1'b0, 4'd5, 4'd9);
    tick();
    check("pause_pre_free", 64'(free_count_out), 64'd7);
    rdy_in = 1'b0;
    set_issue(5'd7, 32'd1, 32'd2, 1'b1, 4'd0, 4'd10);
    cdb_valid_in = 2'b01; cdb_tag_in = {4'd0, 4'd5}; cdb_value_in = {32'd0, 32'h55};
    tick();
    check("pause_free", 64'(free_count_out), 64'd7);
    check("pause_valid", 64'(alu_valid_out), 64'd0);
    rdy_in = 1'b1; issue_in = 1'b0; cdb_valid_in = 2'b00;
    tick();
    tick();
    check("pause_no_wake_valid", 64'(alu_valid_out), 64'd0);
    check("pause_no_wake_free", 64'(free_count_out), 64'd7);
    flush_in = 1'b1;
    set_issue(5'd7, 32'd1, 32'd2, 1'b1, 4'd0, 4'd11);
    tick();
    flush_in = 1'b0; issue_in = 1'b0;
    check("flush_issue_free", 64'(free_count_out), 64'd8);
    tick();
    check("flush_issue_valid", 64'(alu_valid_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
